// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter: two requesters and one result consumer.
interface alu_arbiter_if #(parameter int W = 4);
   logic           req0_valid;
   logic [W-1:0]   req0_a;
   logic [W-1:0]   req0_b;
   logic [3:0]     req0_op;
   logic           req0_ready;
   logic           req1_valid;
   logic [W-1:0]   req1_a;
   logic [W-1:0]   req1_b;
   logic [3:0]     req1_op;
   logic           req1_ready;
   logic           rsp_valid;
   logic           rsp_id;
   logic [2*W-1:0] rsp_result;
   logic           rsp_err;
   logic           rsp_ready;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_err
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a registered ALU (IDLE/EXEC/RESP).
// Define ALU_ARB_ERR_EN to flag division by zero and opcodes 0/15 on rsp_err.
module alu_arbiter #(
   parameter int W = 4
) (
   input  logic          clk,
   input  logic          rst,
   alu_arbiter_if.slave  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]     state_r;
   logic           last_r;
   logic           gnt0_s;
   logic           gnt1_s;
   logic           accept_s;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic [3:0]     op_r;
   logic           id_r;
   logic [2*W-1:0] result_s;
   logic           err_s;
   logic           rsp_valid_r;
   logic           rsp_id_r;
   logic [2*W-1:0] rsp_result_r;
   logic           rsp_err_r;

   function automatic logic [2*W-1:0] alu_calc(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic [3:0]   op);
      logic [2*W-1:0] ax;
      logic [2*W-1:0] bx;
      logic [2*W-1:0] one;
      ax  = {{W{1'b0}}, a};
      bx  = {{W{1'b0}}, b};
      one = {{(2*W-1){1'b0}}, 1'b1};
      case (op)
         4'd1:    alu_calc = ax + bx;
         4'd2:    alu_calc = ax - bx;
         4'd3:    alu_calc = ax * bx;
         4'd4:    alu_calc = (b == {W{1'b0}}) ? {(2*W){1'b1}} : ax / bx;
         4'd5:    alu_calc = ax & bx;
         4'd6:    alu_calc = ax | bx;
         4'd7:    alu_calc = ax << 2'd3;
         4'd8:    alu_calc = ax >> 2'd3;
         4'd9:    alu_calc = bx << 2'd3;
         4'd10:   alu_calc = bx >> 2'd3;
         4'd11:   alu_calc = ax + one;
         4'd12:   alu_calc = ax - one;
         4'd13:   alu_calc = bx + one;
         4'd14:   alu_calc = bx - one;
         default: alu_calc = {(2*W){1'b0}};
      endcase
   endfunction

   // Round-robin grant; last_r set means requester 1 won the previous accept.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (!rst && state_r == IDLE) begin
         if (bus.req0_valid && (!bus.req1_valid || last_r)) begin
            gnt0_s = 1'b1;
         end else if (bus.req1_valid) begin
            gnt1_s = 1'b1;
         end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   assign accept_s = gnt0_s | gnt1_s;
   assign result_s = alu_calc(a_r, b_r, op_r);

   // Error flag for the captured operation.
   always_comb begin
      err_s = 1'b0;
`ifdef ALU_ARB_ERR_EN
      if (op_r == 4'd0 || op_r == 4'd15 || (op_r == 4'd4 && b_r == {W{1'b0}})) begin
         err_s = 1'b1;
      end else begin
         err_s = 1'b0;
      end
`endif
   end

   // Sequencer: capture on accept, compute in EXEC, hold the response until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         last_r       <= 1'b1;
         a_r          <= {W{1'b0}};
         b_r          <= {W{1'b0}};
         op_r         <= 4'd0;
         id_r         <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_id_r     <= 1'b0;
         rsp_result_r <= {(2*W){1'b0}};
         rsp_err_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r     <= gnt1_s ? bus.req1_a  : bus.req0_a;
                  b_r     <= gnt1_s ? bus.req1_b  : bus.req0_b;
                  op_r    <= gnt1_s ? bus.req1_op : bus.req0_op;
                  id_r    <= gnt1_s;
                  last_r  <= gnt1_s;
                  state_r <= EXEC;
               end else begin
                  state_r <= IDLE;
               end
            end
            EXEC: begin
               rsp_result_r <= result_s;
               rsp_err_r    <= err_s;
               rsp_id_r     <= id_r;
               rsp_valid_r  <= 1'b1;
               state_r      <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= RESP;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bus.req0_ready = gnt0_s;
   assign bus.req1_ready = gnt1_s;
   assign bus.rsp_valid  = rsp_valid_r;
   assign bus.rsp_id     = rsp_id_r;
   assign bus.rsp_result = rsp_result_r;
   assign bus.rsp_err    = rsp_err_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter against an arithmetic reference model.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic tb_last;

   always #5 clk = ~clk;

   alu_arbiter_if #(.W(4)) bus();
   alu_arbiter #(.W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic logic [7:0] exp_result(input int a, input int b, input int op);
      int r;
      case (op)
         1:       r = a + b;
         2:       r = a - b;
         3:       r = a * b;
         4:       r = (b == 0) ? 255 : a / b;
         5:       r = a & b;
         6:       r = a | b;
         7:       r = a * 8;
         8:       r = a / 8;
         9:       r = b * 8;
         10:      r = b / 8;
         11:      r = a + 1;
         12:      r = a - 1;
         13:      r = b + 1;
         14:      r = b - 1;
         default: r = 0;
      endcase
      r = ((r % 256) + 256) % 256;
      return r[7:0];
   endfunction

   function automatic logic exp_err(input int b, input int op);
`ifdef ALU_ARB_ERR_EN
      return (op == 0 || op == 15 || (op == 4 && b == 0));
`else
      return 1'b0;
`endif
   endfunction

   function automatic int exp_grant(input logic v0, input logic v1);
      if (v0 && v1) return tb_last ? 0 : 1;
      else if (v0)  return 0;
      else          return 1;
   endfunction

   task automatic issue(input logic v0, input logic v1,
                        input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] op0,
                        input logic [3:0] a1, input logic [3:0] b1, input logic [3:0] op1,
                        output int gnt, output int lat, output logic id,
                        output logic [7:0] res, output logic e);
      int wait_n;
      @(negedge clk);
      bus.rsp_ready  = 1'b1;
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
      gnt = -1; wait_n = 0; lat = -1; id = 1'b0; res = 8'h00; e = 1'b0;
      #1;
      while (gnt < 0 && wait_n < 8) begin
         if (bus.req0_ready) gnt = 0;
         else if (bus.req1_ready) gnt = 1;
         else begin
            @(negedge clk); #1; wait_n++;
         end
      end
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if (gnt >= 0) begin
         lat = 1;
         while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk); lat++;
         end
         id = bus.rsp_id; res = bus.rsp_result; e = bus.rsp_err;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.rsp_ready = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = 4'h1; bus.req0_b = 4'h1; bus.req0_op = 4'd1;
      bus.req1_valid = 1'b1; bus.req1_a = 4'h2; bus.req1_b = 4'h2; bus.req1_op = 4'd1;
      @(negedge clk); @(negedge clk); #1;
      checks += 6;
      if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b want 0", bus.req0_ready); end
      if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b want 0", bus.req1_ready); end
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
      if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b want 0", bus.rsp_id); end
      if (bus.rsp_result !== 8'h00) begin errors++; $display("FAIL reset_rsp_result got %h want 00", bus.rsp_result); end
      if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
      @(negedge clk);
      rst = 1'b0;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      tb_last = 1'b1;
   endtask

   task automatic test_basic();
      int g, l; logic id, e; logic [7:0] r;
      issue(1'b1, 1'b0, 4'h3, 4'h5, 4'd1, 4'h0, 4'h0, 4'd0, g, l, id, r, e);
      tb_last = 1'b0;
      checks += 4;
      if (g !== 0) begin errors++; $display("FAIL basic_grant got %0d want 0", g); end
      if (l !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", l); end
      if (id !== 1'b0) begin errors++; $display("FAIL basic_id got %b want 0", id); end
      if (r !== 8'h08) begin errors++; $display("FAIL basic_result got %h want 08", r); end
   endtask

   task automatic test_back_to_back();
      int eg;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      tb_last = 1'b1;
      bus.rsp_ready = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 4'h4; bus.req0_b = 4'h2; bus.req0_op = 4'd1;
      bus.req1_valid = 1'b1; bus.req1_a = 4'h6; bus.req1_b = 4'h1; bus.req1_op = 4'd2;
      for (int k = 0; k < 12; k++) begin
         #1;
         eg = -1;
         if (k % 3 == 0) begin
            eg = exp_grant(1'b1, 1'b1);
            tb_last = (eg == 1);
         end
         checks += 2;
         if (bus.req0_ready !== (eg == 0)) begin errors++; $display("FAIL rr_ready0 cycle %0d got %b want %b", k, bus.req0_ready, (eg == 0)); end
         if (bus.req1_ready !== (eg == 1)) begin errors++; $display("FAIL rr_ready1 cycle %0d got %b want %b", k, bus.req1_ready, (eg == 1)); end
         @(negedge clk);
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
   endtask

   task automatic test_div_zero();
      int g, l; logic id, e; logic [7:0] r;
      issue(1'b0, 1'b1, 4'h0, 4'h0, 4'd0, 4'h9, 4'h0, 4'd4, g, l, id, r, e);
      tb_last = 1'b1;
      checks += 4;
      if (g !== 1) begin errors++; $display("FAIL div0_grant got %0d want 1", g); end
      if (id !== 1'b1) begin errors++; $display("FAIL div0_id got %b want 1", id); end
      if (r !== 8'hFF) begin errors++; $display("FAIL div0_result got %h want ff", r); end
      if (e !== exp_err(0, 4)) begin errors++; $display("FAIL div0_err got %b want %b", e, exp_err(0, 4)); end
   endtask

   task automatic test_stall();
      logic [7:0] hr; logic hid, he;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = 4'h3; bus.req0_b = 4'h5; bus.req0_op = 4'd1;
      #1; checks++;
      if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL stall_accept got %b want 1", bus.req0_ready); end
      tb_last = 1'b0;
      @(negedge clk); #1; checks++;
      if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL stall_exec_ready got %b want 0", bus.req0_ready); end
      @(negedge clk); #1;
      hr = bus.rsp_result; hid = bus.rsp_id; he = bus.rsp_err;
      checks += 2;
      if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", bus.rsp_valid); end
      if (hr !== 8'h08) begin errors++; $display("FAIL stall_result got %h want 08", hr); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'h08 || bus.rsp_id !== 1'b0 ||
             bus.rsp_err !== he || bus.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cycle %0d got v=%b r=%h id=%b e=%b rdy=%b want v=1 r=08 id=0 e=%b rdy=0",
                     i, bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.rsp_err, bus.req0_ready, he);
         end
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      #1; checks++;
      if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL stall_hs_ready got %b want 0", bus.req0_ready); end
      @(negedge clk); #1;
      checks += 2;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_drop got %b want 0", bus.rsp_valid); end
      if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL stall_reaccept got %b want 1", bus.req0_ready); end
      tb_last = 1'b0;
      @(negedge clk);
      bus.req0_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'h08) begin
         errors++; $display("FAIL stall_second got v=%b r=%h want v=1 r=08", bus.rsp_valid, bus.rsp_result);
      end
   endtask

   task automatic test_reset_exec();
      int g, l; logic id, e; logic [7:0] r;
      int seen;
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 4'h2; bus.req0_b = 4'h2; bus.req0_op = 4'd3;
      #1; checks++;
      if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rstx_accept got %b want 1", bus.req0_ready); end
      @(negedge clk);
      bus.req0_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tb_last = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (bus.rsp_valid) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL rstx_no_rsp got %0d valid cycles want 0", seen); end
      issue(1'b1, 1'b1, 4'hF, 4'h0, 4'd7, 4'h5, 4'h5, 4'd1, g, l, id, r, e);
      checks += 2;
      if (g !== exp_grant(1'b1, 1'b1)) begin errors++; $display("FAIL rstx_grant got %0d want 0", g); end
      if (r !== 8'h78) begin errors++; $display("FAIL rstx_result got %h want 78", r); end
      tb_last = 1'b0;
   endtask

   task automatic test_sweep();
      int g, l; logic id, e; logic [7:0] r;
      for (int op = 0; op < 16; op++) begin
         issue(1'b1, 1'b0, 4'hA, 4'h3, op[3:0], 4'h0, 4'h0, 4'd0, g, l, id, r, e);
         tb_last = 1'b0;
         checks += 2;
         if (r !== exp_result(10, 3, op)) begin errors++; $display("FAIL sweep_result op %0d got %h want %h", op, r, exp_result(10, 3, op)); end
         if (e !== exp_err(3, op)) begin errors++; $display("FAIL sweep_err op %0d got %b want %b", op, e, exp_err(3, op)); end
      end
   endtask

   task automatic test_random();
      int g, l, eg; logic id, e; logic [7:0] r;
      logic v0, v1; logic [3:0] a0, b0, o0, a1, b1, o1;
      int ea, eb, eo;
      for (int n = 0; n < 30; n++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
         a0 = 4'($urandom); b0 = 4'($urandom); o0 = 4'($urandom);
         a1 = 4'($urandom); b1 = 4'($urandom); o1 = 4'($urandom);
         if (n % 5 == 0) begin b0 = 4'h0; b1 = 4'h0; o0 = 4'd4; o1 = 4'd4; end
         eg = exp_grant(v0, v1);
         ea = (eg == 0) ? int'(a0) : int'(a1);
         eb = (eg == 0) ? int'(b0) : int'(b1);
         eo = (eg == 0) ? int'(o0) : int'(o1);
         issue(v0, v1, a0, b0, o0, a1, b1, o1, g, l, id, r, e);
         tb_last = (eg == 1);
         checks += 5;
         if (g !== eg) begin errors++; $display("FAIL rand_grant n %0d got %0d want %0d", n, g, eg); end
         if (l !== 2) begin errors++; $display("FAIL rand_latency n %0d got %0d want 2", n, l); end
         if (id !== (eg == 1)) begin errors++; $display("FAIL rand_id n %0d got %b want %0d", n, id, eg); end
         if (r !== exp_result(ea, eb, eo)) begin errors++; $display("FAIL rand_result n %0d got %h want %h", n, r, exp_result(ea, eb, eo)); end
         if (e !== exp_err(eb, eo)) begin errors++; $display("FAIL rand_err n %0d got %b want %b", n, e, exp_err(eb, eo)); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rsp_ready = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_a = 4'h0; bus.req0_b = 4'h0; bus.req0_op = 4'd0;
      bus.req1_valid = 1'b0; bus.req1_a = 4'h0; bus.req1_b = 4'h0; bus.req1_op = 4'd0;
      tb_last = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_stall();
      test_reset_exec();
      test_sweep();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
